// File: rtl/mult_pipe_sa.sv
// Fully pipelined shift-add multiplier: WB stages, one multiplier bit retired per stage,
// per-op signed/unsigned mode, tag sideband, valid/ready with global stall and flush.
module mult_pipe_sa #(
   parameter int WA    = 8,
   parameter int WB    = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_en,
   input  logic [WA-1:0]    mult_1,
   input  logic [WB-1:0]    mult_2,
   input  logic [TAG_W-1:0] in_tag,
   output logic [WA+WB-1:0] result,
   output logic [TAG_W-1:0] out_tag,
   output logic             result_rdy,
   input  logic             out_ready,
   output logic             busy
);
   localparam int WP = WA + WB;

   logic             vld_p  [WB];
   logic [WP-1:0]    psum_p [WB];
   logic [TAG_W-1:0] tag_p  [WB];
   // the output stage only needs the finished sum, so operand/mode state stops one stage short
   logic [WP-1:0]    a_p    [WB-1];
   logic [WB-1:0]    b_p    [WB-1];
   logic             sgn_p  [WB-1];
   logic             advance;

   function automatic logic [WP-1:0] extend(input logic [WA-1:0] v, input logic s);
      return {{WB{s & v[WA-1]}}, v};
   endfunction

   function automatic logic [WP-1:0] step(input logic [WP-1:0] p, input logic [WP-1:0] a,
                                          input logic bit_k, input logic neg);
      if (!bit_k) return p;
      return neg ? p - a : p + a;
   endfunction

   assign advance    = !vld_p[WB-1] || out_ready;
   assign in_ready   = advance;
   assign result     = psum_p[WB-1];
   assign out_tag    = tag_p[WB-1];
   assign result_rdy = vld_p[WB-1];

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < WB; k++) busy = busy | vld_p[k];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < WB; k++) begin
            vld_p[k]  <= 1'b0;
            psum_p[k] <= '0;
            tag_p[k]  <= '0;
         end
         for (int k = 0; k < WB-1; k++) begin
            a_p[k]   <= '0;
            b_p[k]   <= '0;
            sgn_p[k] <= 1'b0;
         end
      end else begin
         if (flush) begin
            for (int k = 0; k < WB; k++) vld_p[k] <= 1'b0;
         end else if (advance) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < WB; k++) vld_p[k] <= vld_p[k-1];
         end

         if (advance) begin
            // S0 retires multiplier bit 0 on load; b_p holds only the bits still to be applied
            a_p[0]    <= extend(mult_1, signed_en);
            b_p[0]    <= mult_2 >> 1;
            sgn_p[0]  <= signed_en;
            tag_p[0]  <= in_tag;
            psum_p[0] <= mult_2[0] ? extend(mult_1, signed_en) : '0;
            for (int k = 1; k < WB-1; k++) begin
               a_p[k]   <= a_p[k-1] << 1;
               b_p[k]   <= b_p[k-1] >> 1;
               sgn_p[k] <= sgn_p[k-1];
            end
            // the multiplier MSB carries negative weight for two's complement operands
            for (int k = 1; k < WB; k++) begin
               psum_p[k] <= step(psum_p[k-1], a_p[k-1] << 1, b_p[k-1][0],
                                 (k == WB-1) && sgn_p[k-1]);
               tag_p[k]  <= tag_p[k-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_mult_pipe_sa.sv
// Bench for mult_pipe_sa: fixed vectors, random traffic against an arithmetic model,
// backpressure, flush, reset, and a WA=12/WB=5 instance.
module tb_mult_pipe_sa;
   localparam int WA = 8, WB = 8, TW = 4;
   localparam int WA2 = 12, WB2 = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, flush, in_valid, in_ready, signed_en, out_ready, result_rdy, busy;
   logic [WA-1:0]    mult_1;
   logic [WB-1:0]    mult_2;
   logic [TW-1:0]    in_tag, out_tag;
   logic [WA+WB-1:0] result;

   logic flush_s, in_valid_s, in_ready_s, signed_en_s, out_ready_s, result_rdy_s, busy_s;
   logic [WA2-1:0]     mult_1_s;
   logic [WB2-1:0]     mult_2_s;
   logic [TW-1:0]      in_tag_s, out_tag_s;
   logic [WA2+WB2-1:0] result_s;

   mult_pipe_sa #(.WA(WA), .WB(WB), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .signed_en(signed_en), .mult_1(mult_1), .mult_2(mult_2), .in_tag(in_tag),
      .result(result), .out_tag(out_tag), .result_rdy(result_rdy), .out_ready(out_ready),
      .busy(busy));

   mult_pipe_sa #(.WA(WA2), .WB(WB2), .TAG_W(TW)) dut_s (
      .clk(clk), .rst_n(rst_n), .flush(flush_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .signed_en(signed_en_s), .mult_1(mult_1_s), .mult_2(mult_2_s), .in_tag(in_tag_s),
      .result(result_s), .out_tag(out_tag_s), .result_rdy(result_rdy_s), .out_ready(out_ready_s),
      .busy(busy_s));

   int total = 0, bad = 0;

   typedef struct { longint res; longint tag; } exp_t;
   exp_t q8[$], q5[$];

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      bit          sgn;
      logic [3:0]  tag;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // plain integer product, interpreted per mode, reduced modulo 2^(wa+wb)
   function automatic longint ref_mul(input longint a, input longint b, input int wa,
                                      input int wb, input bit s);
      longint x = a, y = b;
      if (s && ((a >> (wa-1)) & 1) != 0) x = a - (longint'(1) << wa);
      if (s && ((b >> (wb-1)) & 1) != 0) y = b - (longint'(1) << wb);
      return (x * y) & ((longint'(1) << (wa+wb)) - 1);
   endfunction

   always @(posedge clk) begin : mon8
      exp_t e;
      if (!rst_n) q8.delete();
      else begin
         if (result_rdy && out_ready) begin
            chk("out8_expected_pending", q8.size() > 0, 1);
            if (q8.size() > 0) begin
               e = q8.pop_front();
               chk("out8_product", result, e.res);
               chk("out8_tag", out_tag, e.tag);
            end
         end
         if (flush) q8.delete();
         else if (in_valid && in_ready)
            q8.push_back('{ref_mul(mult_1, mult_2, WA, WB, signed_en), longint'(in_tag)});
      end
   end

   always @(posedge clk) begin : mon5
      exp_t e;
      if (!rst_n) q5.delete();
      else begin
         if (result_rdy_s && out_ready_s) begin
            chk("out5_expected_pending", q5.size() > 0, 1);
            if (q5.size() > 0) begin
               e = q5.pop_front();
               chk("out5_product", result_s, e.res);
               chk("out5_tag", out_tag_s, e.tag);
            end
         end
         if (flush_s) q5.delete();
         else if (in_valid_s && in_ready_s)
            q5.push_back('{ref_mul(mult_1_s, mult_2_s, WA2, WB2, signed_en_s), longint'(in_tag_s)});
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic run_vec(input vec_t v);
      int k;
      in_valid = 1'b1; mult_1 = v.a; mult_2 = v.b; signed_en = v.sgn; in_tag = v.tag;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 0;
      while (!result_rdy && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("vec_latency", k, WB-1);
      chk("vec_result", result, v.exp);
      chk("vec_tag", out_tag, v.tag);
   endtask

   initial begin
      int k, run, maxrun;
      bit seen;
      logic [15:0] held_res;
      logic [3:0]  held_tag;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; signed_en = 1'b0;
      mult_1 = '0; mult_2 = '0; in_tag = '0; out_ready = 1'b1;
      flush_s = 1'b0; in_valid_s = 1'b0; signed_en_s = 1'b0;
      mult_1_s = '0; mult_2_s = '0; in_tag_s = '0; out_ready_s = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_rdy", result_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;

      vecs[0] = '{8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01};
      vecs[1] = '{8'h80, 8'h80, 1'b1, 4'd1, 16'h4000};
      vecs[2] = '{8'hFF, 8'h7F, 1'b1, 4'd2, 16'hFF81};
      vecs[3] = '{8'h7F, 8'h80, 1'b1, 4'd4, 16'hC080};
      vecs[4] = '{8'h00, 8'hFB, 1'b1, 4'd5, 16'h0000};
      vecs[5] = '{8'hFF, 8'h01, 1'b1, 4'd6, 16'hFFFF};
      vecs[6] = '{8'h12, 8'h34, 1'b0, 4'd7, 16'h03A8};
      vecs[7] = '{8'h80, 8'hFF, 1'b0, 4'd8, 16'h7F80};
      foreach (vecs[i]) run_vec(vecs[i]);

      // back-to-back random traffic at full rate
      out_ready = 1'b1; run = 0; maxrun = 0;
      for (int i = 0; i < 16 + WB + 4; i++) begin
         if (i < 16) begin
            in_valid = 1'b1; signed_en = 1'($urandom_range(0, 1));
            mult_1 = WA'($urandom); mult_2 = WB'($urandom); in_tag = TW'(i);
            chk("b2b_in_ready", in_ready, 1);
         end else in_valid = 1'b0;
         @(posedge clk); #1;
         if (result_rdy) begin
            run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
      end
      chk("b2b_run", maxrun, 16);

      // backpressure: fill, stall 5 cycles, release
      out_ready = 1'b0; k = 0;
      while (!result_rdy && k < 40) begin
         in_valid = 1'b1; signed_en = 1'($urandom_range(0, 1));
         mult_1 = WA'($urandom); mult_2 = WB'($urandom); in_tag = TW'(k);
         @(posedge clk); #1;
         k++;
      end
      chk("bp_fill", result_rdy, 1);
      held_res = result; held_tag = out_tag;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; mult_1 = WA'($urandom); mult_2 = WB'($urandom); in_tag = TW'(i + 9);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("bp_result_hold", result, held_res);
         chk("bp_tag_hold", out_tag, held_tag);
         chk("bp_rdy_hold", result_rdy, 1);
      end
      in_valid = 1'b0; out_ready = 1'b1; k = 0;
      while ((busy || q8.size() != 0) && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("bp_drained", q8.size(), 0);

      // flush with 4 ops in flight and an input offered in the flush cycle
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; signed_en = 1'b0;
         mult_1 = WA'($urandom) | 8'h01; mult_2 = WB'($urandom) | 8'h01; in_tag = TW'(i);
         @(posedge clk); #1;
      end
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_rdy", result_rdy, 0);
      chk("flush_busy", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < WB + 2; i++) begin
         @(posedge clk); #1;
         if (result_rdy || busy) seen = 1'b1;
      end
      chk("flush_no_result", seen, 0);

      // reset mid-flight
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; signed_en = 1'b1;
         mult_1 = WA'($urandom) | 8'h01; mult_2 = WB'($urandom) | 8'h01; in_tag = TW'(i + 1);
         @(posedge clk); #1;
      end
      rst_n = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rst2_result", result, 0);
      chk("rst2_tag", out_tag, 0);
      chk("rst2_rdy", result_rdy, 0);
      chk("rst2_busy", busy, 0);
      rst_n = 1'b1; in_valid = 1'b0;

      // WA=12, WB=5 instance: single-op latency, then random mix with random backpressure
      in_valid_s = 1'b1; signed_en_s = 1'b1; mult_1_s = 12'h801; mult_2_s = 5'h13; in_tag_s = 4'hA;
      @(posedge clk); #1;
      in_valid_s = 1'b0; k = 0;
      while (!result_rdy_s && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("s_latency", k, WB2-1);
      for (int i = 0; i < 60; i++) begin
         in_valid_s = 1'($urandom_range(0, 3) != 0); signed_en_s = 1'($urandom_range(0, 1));
         mult_1_s = WA2'($urandom); mult_2_s = WB2'($urandom); in_tag_s = TW'($urandom);
         out_ready_s = 1'($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid_s = 1'b0; out_ready_s = 1'b1; k = 0;
      while ((busy_s || q5.size() != 0) && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("s_drained", q5.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
